// File: rtl/des_round_engine.sv
// Iterative DES engine: ROUNDS_PER_CYCLE Feistel rounds per clock with an on-the-fly key
// schedule (C/D rotate left for encrypt, right for decrypt, back to their start after 16 rounds).
module des_round_engine #(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic        Clk,
    input  logic        RstN,
    input  logic        InValid,
    output logic        InReady,
    input  logic        Decrypt,
    input  logic [63:0] DataIn,
    input  logic [63:0] KeyIn,
    output logic        OutValid,
    input  logic        OutReady,
    output logic [63:0] DataOut,
    output logic        Busy
);

    generate
        if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 4 ||
              ROUNDS_PER_CYCLE == 8 || ROUNDS_PER_CYCLE == 16)) begin : g_bad_rpc
            $error("des_round_engine: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    localparam logic [4:0] STEP = 5'(ROUNDS_PER_CYCLE);

    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
    localparam int FP_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};
    localparam int E_T [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,  8,  9, 10, 11,
        12, 13, 12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21,
        22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
    localparam int P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10, 23, 19, 12,  4,
        26,  8, 16,  7, 27, 20, 13,  2, 41, 52, 31, 37, 47, 55, 30, 40,
        51, 45, 33, 48, 44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    localparam logic [255:0] SBOX [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;

    function automatic logic [63:0] ip_perm(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_T[i]];
        return y;
    endfunction

    function automatic logic [63:0] fp_perm(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++) y[63-i] = x[64-FP_T[i]];
        return y;
    endfunction

    function automatic logic [55:0] pc1_perm(input logic [63:0] x);
        logic [55:0] y;
        y = '0;
        for (int i = 0; i < 56; i++) y[55-i] = x[64-PC1_T[i]];
        return y;
    endfunction

    function automatic logic [47:0] pc2_perm(input logic [55:0] x);
        logic [47:0] y;
        y = '0;
        for (int i = 0; i < 48; i++) y[47-i] = x[56-PC2_T[i]];
        return y;
    endfunction

    function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] x;
        logic [31:0] s;
        logic [31:0] y;
        logic [5:0]  six;
        int unsigned idx;
        x = '0;
        for (int i = 0; i < 48; i++) x[47-i] = r[32-E_T[i]];
        x = x ^ k;
        s = '0;
        for (int b = 0; b < 8; b++) begin
            six = x[47-6*b -: 6];
            idx = 32'({six[5], six[0], six[4:1]});
            s[31-4*b -: 4] = SBOX[b][255-4*idx -: 4];
        end
        y = '0;
        for (int i = 0; i < 32; i++) y[31-i] = s[32-P_T[i]];
        return y;
    endfunction

    function automatic logic single_shift(input logic [4:0] rnd);
        return (rnd == 5'd1) || (rnd == 5'd2) || (rnd == 5'd9) || (rnd == 5'd16);
    endfunction

    function automatic logic [27:0] rol28(input logic [27:0] x, input logic one);
        return one ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
    endfunction

    function automatic logic [27:0] ror28(input logic [27:0] x, input logic one);
        return one ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
    endfunction

    state_e      state_q, state_d;
    logic [31:0] l_q, l_d, r_q, r_d;
    logic [27:0] c_q, c_d, d_q, d_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        dec_q, dec_d;
    logic [63:0] dout_q, dout_d;
    logic [27:0] c_init_q, d_init_q;

    // Parity bits never enter the key schedule.
    logic key_parity_unused;
    assign key_parity_unused = ^{KeyIn[56], KeyIn[48], KeyIn[40], KeyIn[32],
                                 KeyIn[24], KeyIn[16], KeyIn[8], KeyIn[0]};

    logic [31:0] l_v, r_v, t_v;
    logic [27:0] c_v, d_v;
    logic [47:0] k_v;
    logic [4:0]  rnd_v;

    always_comb begin
        l_v   = l_q;
        r_v   = r_q;
        c_v   = c_q;
        d_v   = d_q;
        t_v   = '0;
        k_v   = '0;
        rnd_v = '0;
        for (int k = 0; k < ROUNDS_PER_CYCLE; k++) begin
            rnd_v = cnt_q + 5'(k + 1);
            if (!dec_q) begin
                c_v = rol28(c_v, single_shift(rnd_v));
                d_v = rol28(d_v, single_shift(rnd_v));
                k_v = pc2_perm({c_v, d_v});
            end else begin
                // Decrypt undoes the encrypt schedule: subkey first, then rotate back.
                k_v = pc2_perm({c_v, d_v});
                c_v = ror28(c_v, single_shift(5'd17 - rnd_v));
                d_v = ror28(d_v, single_shift(5'd17 - rnd_v));
            end
            t_v = r_v;
            r_v = l_v ^ feistel(r_v, k_v);
            l_v = t_v;
        end
    end

    always_comb begin
        state_d = state_q;
        l_d     = l_q;
        r_d     = r_q;
        c_d     = c_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        dec_d   = dec_q;
        dout_d  = dout_q;
        case (state_q)
            IDLE: begin
                if (InValid) begin
                    {l_d, r_d} = ip_perm(DataIn);
                    {c_d, d_d} = pc1_perm(KeyIn);
                    dec_d      = Decrypt;
                    cnt_d      = '0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                l_d   = l_v;
                r_d   = r_v;
                c_d   = c_v;
                d_d   = d_v;
                cnt_d = cnt_q + STEP;
                if (cnt_d == 5'd16) begin
                    dout_d  = fp_perm({r_v, l_v});
                    state_d = DONE;
                end
            end
            DONE: begin
                if (OutReady) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            state_q <= IDLE;
            l_q     <= '0;
            r_q     <= '0;
            c_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            dec_q   <= 1'b0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            l_q     <= l_d;
            r_q     <= r_d;
            c_q     <= c_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            dec_q   <= dec_d;
            dout_q  <= dout_d;
        end
    end

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            c_init_q <= '0;
            d_init_q <= '0;
        end else if (state_q == IDLE && InValid) begin
            c_init_q <= c_d;
            d_init_q <= d_d;
        end
    end

    a_key_restored: assert property (@(posedge Clk) disable iff (!RstN)
        (state_q == RUN && state_d == DONE) |-> ({c_v, d_v} == {c_init_q, d_init_q}));

    assign InReady  = (state_q == IDLE);
    assign OutValid = (state_q == DONE);
    assign Busy     = (state_q != IDLE);
    assign DataOut  = dout_q;

endmodule

// File: tb/tb_des_round_engine.sv
// Bench: engines at 1, 4 and 16 rounds per clock, compared against a software DES model
// that precomputes all sixteen subkeys and reverses their order for decryption.
module tb_des_round_engine;

    logic        Clk = 1'b0;
    logic        RstN;
    logic        in_valid  [3];
    logic        in_ready  [3];
    logic        dec       [3];
    logic [63:0] din       [3];
    logic [63:0] key       [3];
    logic        out_valid [3];
    logic        out_ready [3];
    logic [63:0] dout      [3];
    logic        busy      [3];
    int          n_chk  = 0;
    int          n_pass = 0;

    always #5 Clk = ~Clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        des_round_engine #(.ROUNDS_PER_CYCLE(g == 0 ? 1 : (g == 1 ? 4 : 16))) u_dut (
            .Clk(Clk), .RstN(RstN),
            .InValid(in_valid[g]), .InReady(in_ready[g]), .Decrypt(dec[g]),
            .DataIn(din[g]), .KeyIn(key[g]),
            .OutValid(out_valid[g]), .OutReady(out_ready[g]), .DataOut(dout[g]),
            .Busy(busy[g])
        );
    end

    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
    localparam int FP_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};
    localparam int E_T [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,  8,  9, 10, 11,
        12, 13, 12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21,
        22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
    localparam int P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10, 23, 19, 12,  4,
        26,  8, 16,  7, 27, 20, 13,  2, 41, 52, 31, 37, 47, 55, 30, 40,
        51, 45, 33, 48, 44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    localparam logic [255:0] SB [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

    function automatic logic [63:0] des_model(input logic [63:0] k64, input logic [63:0] blk,
                                              input logic decrypt);
        logic [55:0] cd;
        logic [27:0] c, d;
        logic [47:0] ks [16];
        logic [47:0] sk, ex;
        logic [63:0] x, y;
        logic [31:0] l, r, t, so, po;
        logic [5:0]  six;
        int          idx;
        cd = '0;
        for (int i = 0; i < 56; i++) cd = {cd[54:0], k64[64-PC1_T[i]]};
        c = cd[55:28];
        d = cd[27:0];
        for (int i = 0; i < 16; i++) begin
            c = (c << SHIFTS[i]) | (c >> (28 - SHIFTS[i]));
            d = (d << SHIFTS[i]) | (d >> (28 - SHIFTS[i]));
            ks[i] = '0;
            for (int j = 0; j < 48; j++) ks[i] = {ks[i][46:0], cd_bit({c, d}, PC2_T[j])};
        end
        x = '0;
        for (int i = 0; i < 64; i++) x = {x[62:0], blk[64-IP_T[i]]};
        l = x[63:32];
        r = x[31:0];
        for (int i = 0; i < 16; i++) begin
            sk = decrypt ? ks[15-i] : ks[i];
            ex = '0;
            for (int j = 0; j < 48; j++) ex = {ex[46:0], r[32-E_T[j]]};
            ex = ex ^ sk;
            so = '0;
            for (int b = 0; b < 8; b++) begin
                six = ex[47-6*b -: 6];
                idx = 16 * (2 * int'(six[5]) + int'(six[0])) + int'(six[4:1]);
                so  = {so[27:0], SB[b][4*(63-idx) +: 4]};
            end
            po = '0;
            for (int j = 0; j < 32; j++) po = {po[30:0], so[32-P_T[j]]};
            t = r;
            r = l ^ po;
            l = t;
        end
        x = {r, l};
        y = '0;
        for (int i = 0; i < 64; i++) y = {y[62:0], x[64-FP_T[i]]};
        return y;
    endfunction

    function automatic logic cd_bit(input logic [55:0] v, input int n);
        return v[56-n];
    endfunction

    function automatic int lat_of(input int u);
        return (u == 0) ? 16 : ((u == 1) ? 4 : 1);
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check_reset_outputs(input int u, input string tag);
        check($sformatf("%s_u%0d_inready", tag, u), 64'(in_ready[u]), 64'd1);
        check($sformatf("%s_u%0d_outvalid", tag, u), 64'(out_valid[u]), 64'd0);
        check($sformatf("%s_u%0d_busy", tag, u), 64'(busy[u]), 64'd0);
        check($sformatf("%s_u%0d_dataout", tag, u), dout[u], 64'd0);
    endtask

    // One block: accept, scramble the inputs, wait for the result, optionally stall, release.
    task automatic run_block(input int u, input logic [63:0] k, input logic [63:0] blk,
                             input logic m, input logic [63:0] exp, input int hold);
        int waited;
        din[u] = blk; key[u] = k; dec[u] = m; in_valid[u] = 1'b1; out_ready[u] = 1'b0;
        tick();
        in_valid[u] = 1'b0; din[u] = {$urandom, $urandom}; key[u] = {$urandom, $urandom}; dec[u] = ~m;
        check($sformatf("u%0d_busy_run", u), 64'(busy[u]), 64'd1);
        waited = 0;
        while (!out_valid[u] && waited < 40) begin
            in_valid[u] = 1'($urandom);
            tick();
            waited++;
        end
        check($sformatf("u%0d_latency", u), 64'(waited), 64'(lat_of(u)));
        check($sformatf("u%0d_data", u), dout[u], exp);
        for (int h = 0; h < hold; h++) begin
            in_valid[u] = 1'($urandom); din[u] = {$urandom, $urandom};
            tick();
            check($sformatf("u%0d_hold_data", u), dout[u], exp);
            check($sformatf("u%0d_hold_valid", u), 64'(out_valid[u]), 64'd1);
            check($sformatf("u%0d_hold_inready", u), 64'(in_ready[u]), 64'd0);
        end
        in_valid[u] = 1'b0; out_ready[u] = 1'b1;
        tick();
        check($sformatf("u%0d_release_valid", u), 64'(out_valid[u]), 64'd0);
        check($sformatf("u%0d_release_inready", u), 64'(in_ready[u]), 64'd1);
        out_ready[u] = 1'b0;
    endtask

    task automatic back_to_back(input int u, input int nblk);
        logic [63:0] q [$];
        logic [63:0] bk, bd;
        logic        bm, will;
        int          cyc, acc, got, last;
        cyc = 0; acc = 0; got = 0; last = -1;
        out_ready[u] = 1'b1;
        while (got < nblk && cyc < 2000) begin
            will = in_ready[u] && (acc < nblk);
            if (will) begin
                bk = {$urandom, $urandom}; bd = {$urandom, $urandom}; bm = 1'($urandom);
                din[u] = bd; key[u] = bk; dec[u] = bm; in_valid[u] = 1'b1;
                q.push_back(des_model(bk, bd, bm));
            end else begin
                din[u] = {$urandom, $urandom}; dec[u] = 1'($urandom); in_valid[u] = (acc < nblk);
            end
            tick();
            cyc++;
            if (will) begin
                if (last >= 0) check($sformatf("u%0d_b2b_period", u), 64'(cyc - last), 64'(lat_of(u) + 2));
                last = cyc;
                acc++;
            end
            if (out_valid[u]) begin
                if (q.size() == 0) check($sformatf("u%0d_b2b_spurious", u), 64'd1, 64'd0);
                else check($sformatf("u%0d_b2b_data", u), dout[u], q.pop_front());
                got++;
            end
        end
        check($sformatf("u%0d_b2b_count", u), 64'(got), 64'(nblk));
        in_valid[u] = 1'b0;
        tick();
        out_ready[u] = 1'b0;
    endtask

    initial begin
        logic [63:0] rk, rd;
        for (int u = 0; u < 3; u++) begin
            in_valid[u] = 1'b0; dec[u] = 1'b0; din[u] = '0; key[u] = '0; out_ready[u] = 1'b0;
        end
        RstN = 1'b1;
        #1 RstN = 1'b0;
        #1;
        for (int u = 0; u < 3; u++) check_reset_outputs(u, "por");
        check("model_enc", des_model(64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 1'b0), 64'h85E813540F0AB405);
        check("model_dec", des_model(64'h133457799BBCDFF1, 64'h85E813540F0AB405, 1'b1), 64'h0123456789ABCDEF);
        repeat (2) @(posedge Clk);
        #1 RstN = 1'b1;

        run_block(0, 64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 1'b0, 64'h85E813540F0AB405, 0);
        run_block(1, 64'h133457799BBCDFF1, 64'h85E813540F0AB405, 1'b1, 64'h0123456789ABCDEF, 0);
        run_block(2, 64'h0E329232EA6D0D73, 64'h8787878787878787, 1'b0, 64'h0, 0);
        run_block(2, 64'h0E329232EA6D0D73 ^ 64'h0101010101010101, 64'h8787878787878787, 1'b0, 64'h0, 0);

        rk = {$urandom, $urandom}; rd = {$urandom, $urandom};
        run_block(1, rk, rd, 1'b0, des_model(rk, rd, 1'b0), 5);
        check("bp_no_second_accept", 64'(busy[1]), 64'd0);

        // Abort a block mid-run: reset must act immediately and suppress the result.
        rk = {$urandom, $urandom}; rd = {$urandom, $urandom};
        din[0] = rd; key[0] = rk; dec[0] = 1'b0; in_valid[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        repeat (7) tick();
        RstN = 1'b0;
        #1;
        check_reset_outputs(0, "rst_run");
        repeat (2) begin
            tick();
            check("rst_hold_outvalid", 64'(out_valid[0]), 64'd0);
        end
        RstN = 1'b1;
        rk = {$urandom, $urandom}; rd = {$urandom, $urandom};
        run_block(0, rk, rd, 1'b1, des_model(rk, rd, 1'b1), 0);

        for (int u = 0; u < 3; u++) back_to_back(u, 20);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/des_round_engine.md
DES_ROUND_ENGINE -- requirements
Module: des_round_engine

Interface
REQ-001 The module SHALL have parameter ROUNDS_PER_CYCLE, default 1: the number of Feistel rounds evaluated per clock; legal values are 1, 2, 4, 8 and 16.
REQ-002 Any other ROUNDS_PER_CYCLE value SHALL cause an elaboration error.
REQ-003 Port Clk, input, 1 bit: single clock; all state SHALL update on its rising edge.
REQ-004 Port RstN, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port InValid, input, 1 bit: DataIn, KeyIn and Decrypt are valid.
REQ-006 Port InReady, output, 1 bit: the engine can accept a block.
REQ-007 Port Decrypt, input, 1 bit: 0 selects encrypt, 1 selects decrypt; sampled at acceptance.
REQ-008 Port DataIn, input, 64 bits: input block; DES bit 1 maps to DataIn[63].
REQ-009 Port KeyIn, input, 64 bits: key including parity bits; bit 1 maps to KeyIn[63].
REQ-010 Port OutValid, output, 1 bit: DataOut holds a finished result.
REQ-011 Port OutReady, input, 1 bit: the downstream accepts the result.
REQ-012 Port DataOut, output, 64 bits: result block.
REQ-013 Port Busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN and DONE. InReady SHALL be 1 only in IDLE, and OutValid SHALL be 1 only in DONE.
REQ-015 IDLE, InValid=1 (acceptance edge): the engine SHALL register L||R = IP(DataIn), C||D = PC-1(KeyIn), the mode, round counter = 0, and go to RUN.
REQ-016 IDLE, InValid=0: the engine SHALL stay in IDLE with no state change.
REQ-017 The PC-1 step SHALL ignore key parity bits (bits 8, 16, ..., 64).
REQ-018 In RUN, each clock SHALL apply ROUNDS_PER_CYCLE chained rounds combinationally and add ROUNDS_PER_CYCLE to the round counter.
REQ-019 Each round SHALL compute L' = R and R' = L xor f(R, K), where f is E-expansion, xor with the 48-bit K, S1..S8, then P.
REQ-020 The shift for round i SHALL be 1 for i = 1, 2, 9 and 16, and 2 otherwise.
REQ-021 Encrypt, round i (1..16): the engine SHALL rotate C and D left by shift(i), then take K = PC-2(C||D).
REQ-022 Decrypt, round j (1..16): the engine SHALL take K = PC-2(C||D) from the unrotated C and D, then rotate C and D right by shift(17-j), so the subkeys run K16 down to K1.
REQ-023 When the counter reaches 16, the engine SHALL register DataOut = FP(R16||L16), with the halves swapped, and go to DONE in the same edge.
REQ-024 Latency SHALL be exactly N = 16/ROUNDS_PER_CYCLE clocks from the acceptance edge to the edge that raises OutValid.
REQ-025 In DONE, DataOut and OutValid SHALL hold stable until OutReady=1.
REQ-026 On the first edge in DONE with OutReady=1, the engine SHALL go to IDLE and drop OutValid.
REQ-027 InValid SHALL be ignored outside IDLE, and changes on DataIn, KeyIn and Decrypt after acceptance SHALL NOT affect the result.
REQ-028 The minimum block period with OutReady tied high SHALL be N+2 clocks.
REQ-029 After 16 rounds, C and D SHALL equal their values at acceptance in both modes; this is checkable as an internal assertion.

Reset
REQ-030 While RstN=0, the state SHALL be IDLE, with InReady=1, OutValid=0, Busy=0, DataOut=0, and L, R, C, D, the counter and the mode register all 0.
REQ-031 Reset SHALL take effect immediately, without waiting for a Clk edge.
REQ-032 Reset asserted in RUN or DONE SHALL abort the block with no result emitted, and the engine SHALL accept a new block on the first edge after RstN deasserts.
REQ-033 No output SHALL glitch to a non-reset value while RstN=0.

Verification
REQ-034 R=1, encrypt, KeyIn=133457799BBCDFF1, DataIn=0123456789ABCDEF -> DataOut=85E813540F0AB405, OutValid high exactly 16 clocks after acceptance.
REQ-035 R=4, decrypt, KeyIn=133457799BBCDFF1, DataIn=85E813540F0AB405 -> DataOut=0123456789ABCDEF after exactly 4 clocks.
REQ-036 R=16, encrypt, KeyIn=0E329232EA6D0D73, DataIn=8787878787878787 -> DataOut=0000000000000000 after 1 clock; the same vector gives the same result with every key parity bit flipped.
REQ-037 Backpressure: hold OutReady=0 for 5 clocks in DONE while toggling InValid and DataIn -> DataOut stable, InReady=0, and no second acceptance; then OutReady=1 -> IDLE on the next edge.
REQ-038 Reset pulse in RUN at round 7 (R=1) -> OutValid never rises for that block; the next block is accepted 1 clock after deassertion and gives the correct result.
REQ-039 Back-to-back: 20 random encrypt/decrypt blocks with OutReady=1, each checked against a software DES model, with one acceptance every N+2 clocks.
